// File: rtl/simon_cipher_sched_if.sv
// rtl/simon_cipher_sched_if.sv - key/block/result handshake bundle for the Simon32/64 sequencer
interface simon_cipher_sched_if;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
    logic        blk_valid;
    logic        blk_ready;
    logic [31:0] blk_in;
    logic        blk_dec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        key_loaded;
    logic        busy;

    // Host/consumer side: drives keys, blocks and result back-pressure
    modport master (
        output key_valid, key_in, blk_valid, blk_in, blk_dec, out_ready,
        input  key_ready, blk_ready, out_valid, out_data, key_loaded, busy
    );

    // Sequencer side
    modport slave (
        input  key_valid, key_in, blk_valid, blk_in, blk_dec, out_ready,
        output key_ready, blk_ready, out_valid, out_data, key_loaded, busy
    );
endinterface

// File: rtl/simon_cipher_sched.sv
// rtl/simon_cipher_sched.sv - Simon32/64 key expansion and one-round-per-clock block sequencer
module simon_cipher_sched #(
    parameter int          ROUNDS = 32,
    parameter logic [15:0] KEY_C  = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  rst,
    simon_cipher_sched_if.slave   bus
);

    localparam int KW = $clog2(ROUNDS);
    localparam int CW = $clog2(ROUNDS + 1);

    // z[j] is character j of the string, so character 0 sits in the MSB.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEXP,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     x_q, x_d;
    logic [15:0]     y_q, y_d;
    logic            dec_q, dec_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            key_loaded_q, key_loaded_d;

    logic [15:0]     key_q [ROUNDS];

    logic            key_ready;
    logic            blk_ready;
    logic            key_load;
    logic            key_we;

    logic [KW-1:0]   cnt_k;
    logic [15:0]     k_m1, k_m3, k_m4;
    logic [15:0]     t_mix;
    logic [5:0]      zj;
    logic            z_bit;
    logic [15:0]     key_new;

    logic [KW-1:0]   rk_idx;
    logic [15:0]     rk;
    logic [15:0]     x_n, y_n;

    function automatic logic [15:0] ror1(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] v);
        return {v[2:0], v[15:3]};
    endfunction

    // Simon round function: (rol1 & rol8) ^ rol2
    function automatic logic [15:0] f_simon(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    assign cnt_k = cnt_q[KW-1:0];

    // Key expansion: k[i] from k[i-1], k[i-3], k[i-4] with i = cnt
    assign k_m1    = key_q[cnt_k - KW'(1)];
    assign k_m3    = key_q[cnt_k - KW'(3)];
    assign k_m4    = key_q[cnt_k - KW'(4)];
    assign t_mix   = ror3(k_m1) ^ k_m3;
    assign zj      = 6'(cnt_q) - 6'd4;
    assign z_bit   = Z0[6'd61 - zj];
    assign key_new = KEY_C ^ k_m4 ^ t_mix ^ ror1(t_mix) ^ {15'd0, z_bit};

    // Round datapath: decrypt walks the key file backwards from ROUNDS-1
    assign rk_idx = dec_q ? (KW'(ROUNDS - 1) - cnt_k) : cnt_k;
    assign rk     = key_q[rk_idx];
    assign x_n    = dec_q ? y_q : (y_q ^ f_simon(x_q) ^ rk);
    assign y_n    = dec_q ? (x_q ^ f_simon(y_q) ^ rk) : x_q;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            dec_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dec_q        <= dec_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // Key file: four seed words on accept, then one expanded word per KEYEXP clock
    always_ff @(posedge clk) begin
        if (key_load) begin
            key_q[0] <= bus.key_in[15:0];
            key_q[1] <= bus.key_in[31:16];
            key_q[2] <= bus.key_in[47:32];
            key_q[3] <= bus.key_in[63:48];
        end else if (key_we) begin
            key_q[cnt_k] <= key_new;
        end
    end

    // Next-state, handshakes and datapath control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        dec_d        = dec_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        key_loaded_d = key_loaded_q;
        key_load     = 1'b0;
        key_we       = 1'b0;

        key_ready = (state_q == S_IDLE) || (state_q == S_READY);
        // A pending key always wins over a block in READY
        blk_ready = (state_q == S_READY) && !bus.key_valid;

        case (state_q)
            S_IDLE, S_READY: begin
                if (bus.key_valid) begin
                    key_load = 1'b1;
                    if (ROUNDS == 4) begin
                        // Seed words already form the whole schedule
                        state_d      = S_READY;
                        cnt_d        = '0;
                        key_loaded_d = 1'b1;
                    end else begin
                        state_d      = S_KEYEXP;
                        cnt_d        = CW'(4);
                        key_loaded_d = 1'b0;
                    end
                end else if (blk_ready && bus.blk_valid) begin
                    state_d = S_RUN;
                    x_d     = bus.blk_in[31:16];
                    y_d     = bus.blk_in[15:0];
                    dec_d   = bus.blk_dec;
                    cnt_d   = '0;
                end
            end
            S_KEYEXP: begin
                key_we = 1'b1;
                if (cnt_q == CW'(ROUNDS - 1)) begin
                    state_d      = S_READY;
                    cnt_d        = '0;
                    key_loaded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                x_d = x_n;
                y_d = y_n;
                if (cnt_q == CW'(ROUNDS - 1)) begin
                    state_d     = S_DONE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = {x_n, y_n};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_READY;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.key_ready  = key_ready;
    assign bus.blk_ready  = blk_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.key_loaded = key_loaded_q;
    assign bus.busy       = (state_q == S_KEYEXP) || (state_q == S_RUN) || (state_q == S_DONE);

endmodule

// File: tb/tb_simon_cipher_sched.sv
// tb/tb_simon_cipher_sched.sv - directed bench for simon_cipher_sched
module tb_simon_cipher_sched;

    localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY_Z = 64'h0;
    localparam logic [31:0] PT    = 32'h6565_6877;
    localparam logic [31:0] CT    = 32'hC69B_E9BB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    simon_cipher_sched_if bus();

    simon_cipher_sched #(.ROUNDS(32), .KEY_C(16'hFFFC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL reset_key_loaded got %0b want 0", bus.key_loaded); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %0b want 1", bus.key_ready); end
        checks++; if (bus.blk_ready !== 1'b0) begin errors++; $display("FAIL reset_blk_ready got %0b want 0", bus.blk_ready); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_key_expand(input logic [63:0] k, input string name);
        int n;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        #1;
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL %s key_ready_pre got %0b want 1", name, bus.key_ready); end
        step();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1 || bus.key_loaded !== 1'b0) begin errors++; $display("FAIL %s keyexp_flags busy %0b loaded %0b want 1 0", name, bus.busy, bus.key_loaded); end
        checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL %s keyexp_key_ready got %0b want 0", name, bus.key_ready); end
        n = 0;
        while (bus.key_loaded !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 28) begin errors++; $display("FAIL %s key_loaded_latency got %0d want 28", name, n); end
        checks++; if (bus.key_ready !== 1'b1 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s ready_state key_ready %0b blk_ready %0b busy %0b want 1 1 0", name, bus.key_ready, bus.blk_ready, bus.busy); end
    endtask

    task automatic do_block(input logic [31:0] blk, input logic dec, input logic [31:0] exp, input string name);
        int n;
        bus.blk_in    = blk;
        bus.blk_dec   = dec;
        bus.blk_valid = 1'b1;
        #1;
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL %s blk_ready_pre got %0b want 1", name, bus.blk_ready); end
        step();
        bus.blk_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL %s out_latency got %0d want 32", name, n); end
        checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL %s out_data got %h want %h", name, bus.out_data, exp); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin errors++; $display("FAIL %s after_handshake out_valid %0b blk_ready %0b want 0 1", name, bus.out_valid, bus.blk_ready); end
        checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL %s out_data_kept got %h want %h", name, bus.out_data, exp); end
    endtask

    task automatic test_encrypt();
        do_block(PT, 1'b0, CT, "encrypt");
    endtask

    task automatic test_decrypt();
        do_block(CT, 1'b1, PT, "decrypt");
    endtask

    task automatic test_hold();
        int n;
        bus.blk_in    = PT;
        bus.blk_dec   = 1'b0;
        bus.blk_valid = 1'b1;
        step();
        bus.blk_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL hold out_latency got %0d want 32", n); end
        // Offer another block while stalled; it must not be taken
        bus.blk_in    = CT;
        bus.blk_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== CT) begin errors++; $display("FAIL hold_stable cycle %0d out_valid %0b out_data %h want 1 %h", i, bus.out_valid, bus.out_data, CT); end
            checks++; if (bus.blk_ready !== 1'b0 || bus.key_ready !== 1'b0) begin errors++; $display("FAIL hold_ready cycle %0d blk_ready %0b key_ready %0b want 0 0", i, bus.blk_ready, bus.key_ready); end
        end
        bus.blk_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL hold_release out_valid %0b blk_ready %0b busy %0b want 0 1 0", bus.out_valid, bus.blk_ready, bus.busy); end
    endtask

    task automatic test_rekey_priority();
        int n;
        test_key_expand(KEY_Z, "key_zero");
        bus.key_in    = KEY_A;
        bus.key_valid = 1'b1;
        bus.blk_in    = PT;
        bus.blk_dec   = 1'b0;
        bus.blk_valid = 1'b1;
        #1;
        checks++; if (bus.blk_ready !== 1'b0 || bus.key_ready !== 1'b1) begin errors++; $display("FAIL rekey_priority blk_ready %0b key_ready %0b want 0 1", bus.blk_ready, bus.key_ready); end
        step();
        bus.key_valid = 1'b0;
        #1;
        checks++; if (bus.key_loaded !== 1'b0 || bus.busy !== 1'b1 || bus.blk_ready !== 1'b0) begin errors++; $display("FAIL rekey_keyexp loaded %0b busy %0b blk_ready %0b want 0 1 0", bus.key_loaded, bus.busy, bus.blk_ready); end
        n = 0;
        while (bus.key_loaded !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 28) begin errors++; $display("FAIL rekey key_loaded_latency got %0d want 28", n); end
        checks++; if (bus.blk_ready !== 1'b1) begin errors++; $display("FAIL rekey blk_ready_after got %0b want 1", bus.blk_ready); end
        step();
        bus.blk_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin step(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL rekey out_latency got %0d want 32", n); end
        checks++; if (bus.out_data !== CT) begin errors++; $display("FAIL rekey out_data got %h want %h", bus.out_data, CT); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        bus.blk_in    = PT;
        bus.blk_dec   = 1'b0;
        bus.blk_valid = 1'b1;
        step();
        bus.blk_valid = 1'b0;
        repeat (15) step();
        checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_state busy %0b out_valid %0b want 1 0", bus.busy, bus.out_valid); end
        rst = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin errors++; $display("FAIL midrun_reset_out out_valid %0b out_data %h want 0 0", bus.out_valid, bus.out_data); end
        checks++; if (bus.key_loaded !== 1'b0 || bus.busy !== 1'b0 || bus.key_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset_flags loaded %0b busy %0b key_ready %0b want 0 0 1", bus.key_loaded, bus.busy, bus.key_ready); end
        rst = 1'b1;
        bus.blk_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.blk_ready !== 1'b0 || bus.out_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrun_no_block_without_key cycles %0d want 0", seen); end
        bus.blk_valid = 1'b0;
        test_key_expand(KEY_A, "reload");
        do_block(PT, 1'b0, CT, "reload_encrypt");
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.blk_valid = 1'b0;
        bus.blk_in    = '0;
        bus.blk_dec   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_key_expand(KEY_A, "key_a");
        test_encrypt();
        test_decrypt();
        test_hold();
        test_rekey_priority();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
